// File: rtl/conv_layer_scheduler.sv
// Layer-level sequencer for a single convolution engine: walks every filter,
// clears/starts the engine, counts output pixels and packs them into a linear buffer.
module conv_layer_scheduler #(
    parameter int unsigned numFilters         = 4,
    parameter int unsigned imageRow           = 220,
    parameter int unsigned imageColumn        = 170,
    parameter int unsigned filterRow          = 3,
    parameter int unsigned filterColumn       = 3,
    parameter int unsigned filterAddressWidth = 6,
    parameter int unsigned outAddressWidth    = 18,
    parameter int unsigned dataWidth          = 16,
    parameter int unsigned timeoutCycles      = 400000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          layerStart,
    output logic                          layerBusy,
    output logic                          layerDone,
    output logic                          layerError,
    output logic [7:0]                    filterIndex,
    output logic                          convReset,
    output logic [filterAddressWidth-1:0] filterBaseAddr,
    output logic                          startConvolution,
    input  logic                          convDone_,
    input  logic                          fullConvDone,
    input  logic [dataWidth-1:0]          convDataIn,
    output logic                          outWrEn,
    output logic [outAddressWidth-1:0]    outWrAddr,
    output logic [dataWidth-1:0]          outWrData
);
    localparam int unsigned FAW   = filterAddressWidth;
    localparam int unsigned OAW   = outAddressWidth;
    localparam int unsigned P     = (imageRow - filterRow + 1) * (imageColumn - filterColumn + 1);
    localparam int unsigned FSIZE = filterRow * filterColumn;
    localparam int unsigned PCW   = $clog2(P + 1);
    localparam int unsigned WDW   = $clog2(timeoutCycles + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]     state, state_nxt;
    logic [7:0]     filter_nxt;
    logic [PCW-1:0] pix_cnt, pix_nxt;
    logic [WDW-1:0] wd_cnt, wd_nxt;
    logic           wr_nxt;
    logic           busy_nxt;

    // Next-state, counter and write-request logic
    always_comb begin
        state_nxt  = state;
        filter_nxt = filterIndex;
        pix_nxt    = pix_cnt;
        wd_nxt     = wd_cnt;
        wr_nxt     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (layerStart) begin
                    state_nxt  = S_CLR;
                    filter_nxt = 8'd0;
                end
            end
            S_CLR: begin
                pix_nxt   = '0;
                state_nxt = S_START;
            end
            S_START: begin
                wd_nxt    = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                wd_nxt = (convDone_ || fullConvDone) ? '0 : wd_cnt + WDW'(1);
                // An extra pixel beyond P means the engine and layer geometry disagree
                if (convDone_ && pix_cnt == PCW'(P)) begin
                    state_nxt = S_ERR;
                end else begin
                    if (convDone_) begin
                        wr_nxt  = 1'b1;
                        pix_nxt = pix_cnt + PCW'(1);
                    end
                    if (fullConvDone) begin
                        state_nxt = S_CHECK;
                    end else if (!convDone_ && wd_cnt == WDW'(timeoutCycles - 1)) begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_CHECK: state_nxt = (pix_cnt == PCW'(P)) ? S_NEXT : S_ERR;
            S_NEXT: begin
                if (filterIndex == 8'(numFilters - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    filter_nxt = filterIndex + 8'd1;
                    state_nxt  = S_CLR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == S_CLR) || (state_nxt == S_START) || (state_nxt == S_RUN) ||
                      (state_nxt == S_CHECK) || (state_nxt == S_NEXT);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            pix_cnt          <= '0;
            wd_cnt           <= '0;
            filterIndex      <= 8'd0;
            layerBusy        <= 1'b0;
            layerDone        <= 1'b0;
            layerError       <= 1'b0;
            convReset        <= 1'b0;
            startConvolution <= 1'b0;
            filterBaseAddr   <= '0;
            outWrEn          <= 1'b0;
            outWrAddr        <= '0;
            outWrData        <= '0;
        end else begin
            state            <= state_nxt;
            pix_cnt          <= pix_nxt;
            wd_cnt           <= wd_nxt;
            filterIndex      <= filter_nxt;
            layerBusy        <= busy_nxt;
            layerDone        <= (state_nxt == S_DONE) && (state != S_DONE);
            layerError       <= (state_nxt == S_ERR);
            convReset        <= (state_nxt == S_CLR);
            startConvolution <= (state_nxt == S_START);
            if (state_nxt == S_CLR) begin
                filterBaseAddr <= FAW'(32'(filter_nxt) * FSIZE);
            end
            outWrEn <= wr_nxt;
            if (wr_nxt) begin
                outWrAddr <= OAW'(32'(filterIndex) * P + 32'(pix_cnt));
                outWrData <= convDataIn;
            end
        end
    end
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Randomized bench for conv_layer_scheduler against an abstract per-filter pixel model.
module tb_conv_layer_scheduler;
    localparam int NF = 2;
    localparam int P  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        layerStart;
    logic        layerBusy, layerDone, layerError;
    logic [7:0]  filterIndex;
    logic        convReset;
    logic [5:0]  filterBaseAddr;
    logic        startConvolution;
    logic        convDone_, fullConvDone;
    logic [15:0] convDataIn;
    logic        outWrEn;
    logic [17:0] outWrAddr;
    logic [15:0] outWrData;

    conv_layer_scheduler #(
        .numFilters(NF), .imageRow(5), .imageColumn(5), .filterRow(3), .filterColumn(3),
        .filterAddressWidth(6), .outAddressWidth(18), .dataWidth(16), .timeoutCycles(50)
    ) dut (
        .clk(clk), .reset(reset), .layerStart(layerStart), .layerBusy(layerBusy),
        .layerDone(layerDone), .layerError(layerError), .filterIndex(filterIndex),
        .convReset(convReset), .filterBaseAddr(filterBaseAddr),
        .startConvolution(startConvolution), .convDone_(convDone_),
        .fullConvDone(fullConvDone), .convDataIn(convDataIn), .outWrEn(outWrEn),
        .outWrAddr(outWrAddr), .outWrData(outWrData)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_wr = 0, n_clr = 0, n_start = 0, n_done = 0;
    int mdl_f = 0, mdl_cnt = 0;
    bit mdl_run = 0;
    logic prev_clr = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse counters plus the clear-then-start handshake order
    always @(negedge clk) begin
        if (outWrEn) n_wr++;
        if (convReset) n_clr++;
        if (startConvolution) n_start++;
        if (layerDone) n_done++;
        if (prev_clr) check("clr_then_start", startConvolution, 1);
        prev_clr = convReset;
    end

    // One clock of engine activity; the write it should cause is checked one cycle later
    task automatic cyc(input logic cd, input logic fd, input logic [15:0] d);
        bit exp_wr;
        convDone_ = cd; fullConvDone = fd; convDataIn = d;
        @(posedge clk); #1;
        exp_wr = mdl_run && cd && (mdl_cnt < P);
        check("wr_en", outWrEn, exp_wr);
        if (exp_wr) begin
            check("wr_addr", outWrAddr, mdl_f * P + mdl_cnt);
            check("wr_data", outWrData, d);
        end
        if (mdl_run && cd && mdl_cnt >= P) mdl_run = 0;
        if (mdl_run && fd) mdl_run = 0;
        if (exp_wr) mdl_cnt++;
    endtask

    task automatic wait_start(input int f);
        int k = 0;
        while (!startConvolution && k < 12) begin
            cyc(0, 0, 16'd0);
            k++;
        end
        check("start_seen", startConvolution, 1);
        check("base_addr", filterBaseAddr, f * 9);
        check("filter_idx", filterIndex, f);
    endtask

    task automatic start_layer();
        layerStart = 1'b1;
        cyc(0, 0, 16'd0);
        layerStart = 1'b0;
        check("busy_on_start", layerBusy, 1);
        check("err_cleared", layerError, 0);
    endtask

    // Engine model: n pixels with random gaps, optionally finishing with fullConvDone
    task automatic send_pixels(input int f, input int n, input bit coincide, input bit send_full);
        mdl_f = f;
        mdl_cnt = 0;
        wait_start(f);
        cyc(0, 0, 16'd0);
        mdl_run = 1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) cyc(0, 0, 16'd0);
            cyc(1, coincide && (k == n - 1), 16'($urandom));
        end
        if (!coincide && send_full) begin
            repeat ($urandom_range(0, 3)) cyc(0, 0, 16'd0);
            cyc(0, 1, 16'd0);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (!layerDone && k < 10) begin
            cyc(0, 0, 16'd0);
            k++;
        end
        check("layer_done", layerDone, 1);
        cyc(0, 0, 16'd0);
        check("done_one_cycle", layerDone, 0);
        check("busy_after_done", layerBusy, 0);
        check("no_err_after_done", layerError, 0);
    endtask

    task automatic clean_layer(input bit coincide_first);
        int w0, c0, s0, d0;
        w0 = n_wr; c0 = n_clr; s0 = n_start; d0 = n_done;
        start_layer();
        send_pixels(0, P, coincide_first, 1);
        send_pixels(1, P, 0, 1);
        wait_done();
        check("writes_per_layer", n_wr - w0, NF * P);
        check("clr_pulses", n_clr - c0, NF);
        check("start_pulses", n_start - s0, NF);
        check("done_pulses", n_done - d0, 1);
    endtask

    initial begin
        int w0, d0, k;
        reset = 1'b0; layerStart = 1'b0;
        convDone_ = 1'b0; fullConvDone = 1'b0; convDataIn = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {layerBusy, layerDone, layerError, filterIndex, convReset,
               filterBaseAddr, startConvolution, outWrEn, outWrAddr, outWrData}, 64'd0);
        reset = 1'b1;
        cyc(0, 0, 16'd0);

        // Clean layer with layerStart held high while busy (must not restart)
        w0 = n_wr; d0 = n_done;
        start_layer();
        layerStart = 1'b1;
        send_pixels(0, P, 0, 1);
        layerStart = 1'b0;
        send_pixels(1, P, 0, 1);
        wait_done();
        check("writes_busy_start", n_wr - w0, NF * P);
        check("done_busy_start", n_done - d0, 1);
        check("clr_total", n_clr, NF);

        // Plain clean layer and coincident last-pixel/fullConvDone
        clean_layer(0);
        clean_layer(1);

        // Short image: 8 pixels then fullConvDone
        d0 = n_done;
        start_layer();
        send_pixels(0, P - 1, 0, 1);
        repeat (3) cyc(0, 0, 16'd0);
        check("short_err", layerError, 1);
        check("short_busy", layerBusy, 0);
        check("short_no_done", n_done - d0, 0);
        clean_layer(0);

        // Overrun: tenth pixel suppressed, then stray strobes outside RUN ignored
        start_layer();
        send_pixels(0, P + 1, 0, 0);
        check("overrun_err", layerError, 1);
        check("overrun_busy", layerBusy, 0);
        w0 = n_wr;
        cyc(1, 1, 16'h1234);
        cyc(1, 0, 16'h5678);
        check("stray_no_write", n_wr - w0, 0);
        check("err_sticky", layerError, 1);

        // Hung engine: error after 50 silent RUN cycles
        start_layer();
        mdl_f = 0; mdl_cnt = 0;
        wait_start(0);
        k = 0;
        while (!layerError && k < 100) begin
            cyc(0, 0, 16'd0);
            k++;
        end
        check("timeout_cycles", k, 51);
        check("timeout_busy", layerBusy, 0);

        // Asynchronous reset during filter 1 RUN
        start_layer();
        send_pixels(0, P, 0, 1);
        send_pixels(1, 3, 0, 0);
        convDone_ = 1'b1; convDataIn = 16'hbeef;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_reset_outputs", {layerBusy, layerDone, layerError, filterIndex, convReset,
               filterBaseAddr, startConvolution, outWrEn, outWrAddr, outWrData}, 64'd0);
        mdl_run = 0;
        cyc(1, 0, 16'h1111);
        cyc(1, 1, 16'h2222);
        reset = 1'b1;
        w0 = n_wr;
        repeat (3) cyc(1, 1, 16'h3333);
        check("post_reset_no_write", n_wr - w0, 0);
        check("post_reset_idle", layerBusy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, got %0t expected < 500000", $time);
        $fatal(1);
    end
endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences one single_convolution engine through all filters of a conv layer: per-filter engine clear, filter base address select, startConvolution pulse, output-pixel counting.
- Packs each result pixel into a linear layer output buffer.
- Sits between the layer-level controller (layerStart/layerDone) and the convolution datapath plus output memory.
- Detects pixel-count mismatch and hung-engine conditions.

Parameters:
numFilters, 4, filters in layer (1..255)
imageRow, 220, input rows
imageColumn, 170, input columns
filterRow, 3, filter rows
filterColumn, 3, filter columns
filterAddressWidth, 6, filter memory address width; must hold numFilters*filterRow*filterColumn-1
outAddressWidth, 18, output buffer address width; must hold numFilters*P-1
dataWidth, 16, pixel width (signed)
timeoutCycles, 400000, max cycles in RUN without a convDone_ or fullConvDone

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
layerStart  in  1  start request, sampled in IDLE/DONE/ERR only
layerBusy  out  1  high from accepted start until DONE/ERR
layerDone  out  1  one-cycle pulse, layer finished cleanly
layerError  out  1  sticky error, cleared by next accepted layerStart
filterIndex  out  8  current filter number
convReset  out  1  active-high clear to engine
filterBaseAddr  out  filterAddressWidth  filterIndex*filterRow*filterColumn
startConvolution  out  1  one-cycle start pulse to engine
convDone_  in  1  engine output pixel valid
fullConvDone  in  1  engine finished current image
convDataIn  in  dataWidth  engine output pixel
outWrEn  out  1  output buffer write strobe
outWrAddr  out  outAddressWidth  output buffer address
outWrData  out  dataWidth  output buffer data

Behaviour:
- P = (imageRow-filterRow+1)*(imageColumn-filterColumn+1), elaboration-time constant (default 218*168 = 36624).
- Reset (reset=0, async): state IDLE; every output 0; counters 0; layerError 0.
- States: IDLE, CLR, START, RUN, CHECK, NEXT, DONE, ERR.
- IDLE/DONE/ERR:
  - layerStart=1 -> CLR, filterIndex=0, layerError=0, layerBusy=1.
  - layerDone pulses exactly one cycle on entry to DONE; DONE/ERR otherwise hold.
- CLR:
  - convReset=1 for exactly one cycle.
  - filterBaseAddr updated; it is registered and stable from CLR through end of RUN.
  - pixelCount=0 -> START.
- START: startConvolution=1 for exactly one cycle -> RUN.
- RUN, on convDone_=1:
  - If pixelCount<P: next cycle outWrEn=1, outWrAddr=filterIndex*P+pixelCount, outWrData=convDataIn (1-cycle registered latency); pixelCount++.
  - If pixelCount==P: write suppressed -> ERR.
- RUN, on fullConvDone=1 -> CHECK.
  - If convDone_ and fullConvDone arrive in the same cycle, the pixel is written and counted before CHECK.
- RUN watchdog: counter reloads on any convDone_/fullConvDone; reaching timeoutCycles -> ERR.
- convDone_/fullConvDone outside RUN are ignored (no write, no error).
- CHECK: pixelCount==P -> NEXT; else -> ERR.
- NEXT: filterIndex==numFilters-1 -> DONE; else filterIndex++ -> CLR.
- ERR: layerError=1, layerBusy=0, startConvolution=0, outWrEn=0. Remains until a new layerStart.
- layerBusy=1 in CLR, START, RUN, CHECK, NEXT; 0 elsewhere.
- layerStart while busy: ignored.
- outWrAddr arithmetic is unsigned and never wraps; the address range is contiguous 0..numFilters*P-1.
- Reset mid-layer: immediate return to IDLE. No partial write is issued after reset deasserts.

Test Plan:
- Sim params numFilters=2, imageRow=imageColumn=5, filter 3x3 (P=9).
- Clean layer: layerStart, model returns 9 convDone_ pixels 1..9 then fullConvDone per filter -> 18 writes, addresses 0..17, data in order; filterBaseAddr 0 then 9; exactly one layerDone pulse; layerError=0.
- Handshake timing: check exactly one convReset cycle followed by one startConvolution cycle per filter (2 each total). Check outWrEn lags convDone_ by exactly 1 cycle.
- Coincident end: 9th convDone_ in same cycle as fullConvDone -> address 8 written, CHECK passes, second filter starts.
- Short image: fullConvDone after 8 pixels -> layerError=1, layerBusy=0, no layerDone. Then layerStart -> error cleared, clean rerun with addresses again 0..17.
- Overrun and timeout:
  - 10th convDone_ -> no 10th write, ERR.
  - Separately, timeoutCycles=50 with an engine model that stalls -> ERR at cycle 50 of silence.
- Reset mid-layer: reset=0 during filter 1 RUN -> all outputs 0 asynchronously. layerStart ignored during busy is also checked (no restart).
